// File: rtl/tsetlin_automaton_bank_if.sv
// Feedback/status bundle for tsetlin_automaton_bank.
// TA_LOAD_EN adds the direct state-load request signals.
interface tsetlin_automaton_bank_if #(
  parameter int NUM_TA = 4,
  parameter int CNT_W  = 16
`ifdef TA_LOAD_EN
  , parameter int STATE_BITS = 3
`endif
);
  localparam int IC_W = $clog2(NUM_TA + 1);

  logic              fb_valid;
  logic              freeze;
  logic [NUM_TA-1:0] reward;
  logic [NUM_TA-1:0] penalty;
  logic [NUM_TA-1:0] incl;
  logic [IC_W-1:0]   incl_count;
  logic              flip_pulse;
  logic [CNT_W-1:0]  update_count;
`ifdef TA_LOAD_EN
  localparam int LIDX_W = (NUM_TA > 1) ? $clog2(NUM_TA) : 1;
  logic                  load_valid;
  logic [LIDX_W-1:0]     load_idx;
  logic [STATE_BITS-1:0] load_state;
`endif

  modport master (
    output fb_valid, freeze, reward, penalty,
`ifdef TA_LOAD_EN
    output load_valid, load_idx, load_state,
`endif
    input  incl, incl_count, flip_pulse, update_count
  );

  modport slave (
    input  fb_valid, freeze, reward, penalty,
`ifdef TA_LOAD_EN
    input  load_valid, load_idx, load_state,
`endif
    output incl, incl_count, flip_pulse, update_count
  );
endinterface

// File: rtl/tsetlin_automaton_bank.sv
// Bank of NUM_TA two-action Tsetlin automata with freeze, action popcount,
// action-flip pulse and update counter. TA_LOAD_EN adds a per-automaton state load.
module tsetlin_automaton_bank #(
  parameter int NUM_TA     = 4,
  parameter int STATE_BITS = 3,
  parameter int INIT_STATE = 2 ** (STATE_BITS - 1),
  parameter int CNT_W      = 16
) (
  input logic clk,
  input logic rst_n,
  tsetlin_automaton_bank_if.slave bus
);
  localparam int IC_W = $clog2(NUM_TA + 1);
  localparam logic [STATE_BITS-1:0] INIT  = STATE_BITS'(INIT_STATE);
  localparam logic [STATE_BITS-1:0] S_MAX = '1;
  localparam logic [STATE_BITS-1:0] S_MIN = '0;
  localparam logic [IC_W-1:0] IC_RST = INIT[STATE_BITS-1] ? IC_W'(NUM_TA) : '0;
`ifdef TA_LOAD_EN
  localparam int LIDX_W = (NUM_TA > 1) ? $clog2(NUM_TA) : 1;
`endif

  logic [STATE_BITS-1:0] state_reg  [NUM_TA];
  logic [STATE_BITS-1:0] state_next [NUM_TA];
  logic [NUM_TA-1:0]     incl_next;
  logic [IC_W-1:0]       incl_count_reg, incl_count_next;
  logic                  flip_pulse_reg;
  logic [CNT_W-1:0]      update_count_reg;
  logic                  accept;

  assign accept = bus.fb_valid & ~bus.freeze;

  generate
    for (genvar gi = 0; gi < NUM_TA; gi++) begin : g_ta
      logic [STATE_BITS-1:0] cur;
      logic [STATE_BITS-1:0] nxt;
      logic                  in_incl;

      assign cur     = state_reg[gi];
      assign in_incl = cur[STATE_BITS-1];

      // Reward deepens the current action; penalty pushes toward the midpoint and across it.
      always_comb begin
        nxt = cur;
        if (accept && (bus.reward[gi] ^ bus.penalty[gi])) begin
          if (bus.reward[gi]) begin
            if (in_incl) begin
              if (cur != S_MAX) nxt = cur + 1'b1;
            end else begin
              if (cur != S_MIN) nxt = cur - 1'b1;
            end
          end else begin
            nxt = in_incl ? cur - 1'b1 : cur + 1'b1;
          end
        end
`ifdef TA_LOAD_EN
        if (bus.load_valid && (bus.load_idx == LIDX_W'(gi))) nxt = bus.load_state;
`endif
      end

      assign state_next[gi] = nxt;
      assign incl_next[gi]  = nxt[STATE_BITS-1];
      assign bus.incl[gi]   = in_incl;
    end
  endgenerate

  always_comb begin
    incl_count_next = '0;
    for (int i = 0; i < NUM_TA; i++) begin
      incl_count_next = incl_count_next + IC_W'(incl_next[i]);
    end
  end

  // Idle cycles leave state_next equal to state, so the same writes hold everything and clear the pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_TA; i++) state_reg[i] <= INIT;
      incl_count_reg   <= IC_RST;
      flip_pulse_reg   <= 1'b0;
      update_count_reg <= '0;
    end else begin
      for (int i = 0; i < NUM_TA; i++) state_reg[i] <= state_next[i];
      incl_count_reg   <= incl_count_next;
      flip_pulse_reg   <= |(incl_next ^ bus.incl);
      if (accept) update_count_reg <= update_count_reg + 1'b1;
    end
  end

  assign bus.incl_count   = incl_count_reg;
  assign bus.flip_pulse   = flip_pulse_reg;
  assign bus.update_count = update_count_reg;
endmodule

// File: tb/tb_tsetlin_automaton_bank.sv
// Directed bench for tsetlin_automaton_bank (NUM_TA=4, STATE_BITS=3, INIT_STATE=4, CNT_W=4).
module tb_tsetlin_automaton_bank;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

`ifdef TA_LOAD_EN
  tsetlin_automaton_bank_if #(.NUM_TA(4), .CNT_W(4), .STATE_BITS(3)) bus ();
`else
  tsetlin_automaton_bank_if #(.NUM_TA(4), .CNT_W(4)) bus ();
`endif

  tsetlin_automaton_bank #(.NUM_TA(4), .STATE_BITS(3), .INIT_STATE(4), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] e_inc, input int e_ic,
                           input int e_flip, input int e_cnt);
    check({tag, ".incl"},    int'(bus.incl), int'(e_inc));
    check({tag, ".count"},   int'(bus.incl_count), e_ic);
    check({tag, ".flip"},    int'(bus.flip_pulse), e_flip);
    check({tag, ".updates"}, int'(bus.update_count), e_cnt);
    $display("%s: incl=%b incl_count=%0d flip=%0d update_count=%0d",
             tag, bus.incl, bus.incl_count, bus.flip_pulse, bus.update_count);
  endtask

  task automatic clear_inputs();
    bus.fb_valid = 1'b0;
    bus.freeze   = 1'b0;
    bus.reward   = '0;
    bus.penalty  = '0;
`ifdef TA_LOAD_EN
    bus.load_valid = 1'b0;
    bus.load_idx   = '0;
    bus.load_state = '0;
`endif
  endtask

  // One clock with the given feedback, then check the registered outputs 1 time unit later.
  task automatic upd(input string tag, input logic v, input logic f, input logic [3:0] rw,
                     input logic [3:0] pn, input logic [3:0] e_inc, input int e_ic,
                     input int e_flip, input int e_cnt);
    bus.fb_valid = v;
    bus.freeze   = f;
    bus.reward   = rw;
    bus.penalty  = pn;
    @(posedge clk);
    #1;
    clear_inputs();
    check_all(tag, e_inc, e_ic, e_flip, e_cnt);
  endtask

  initial begin
    clear_inputs();
    #2 rst_n = 1'b0;
    #1 check_all("reset", 4'b1111, 4, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // State 0 climbs 4->5->6->7 and saturates at 7.
    upd("rew0_a", 1, 0, 4'b0001, 4'b0000, 4'b1111, 4, 0, 1);
    upd("rew0_b", 1, 0, 4'b0001, 4'b0000, 4'b1111, 4, 0, 2);
    upd("rew0_c", 1, 0, 4'b0001, 4'b0000, 4'b1111, 4, 0, 3);
    upd("rew0_sat", 1, 0, 4'b0001, 4'b0000, 4'b1111, 4, 0, 4);

    // State 1 crosses the midpoint back and forth under repeated penalty.
    upd("pen1_a", 1, 0, 4'b0000, 4'b0010, 4'b1101, 3, 1, 5);
    upd("idle",   0, 0, 4'b0000, 4'b0000, 4'b1101, 3, 0, 5);
    upd("pen1_b", 1, 0, 4'b0000, 4'b0010, 4'b1111, 4, 1, 6);
    upd("pen1_c", 1, 0, 4'b0000, 4'b0010, 4'b1101, 3, 1, 7);
    upd("pen1_d", 1, 0, 4'b0000, 4'b0010, 4'b1111, 4, 1, 8);
    upd("pen1_e", 1, 0, 4'b0000, 4'b0010, 4'b1101, 3, 1, 9);

    // States now [7,3,4,4].
    upd("both",     1, 0, 4'b1111, 4'b1111, 4'b1101, 3, 0, 10);
    upd("freeze",   1, 1, 4'b0000, 4'b1111, 4'b1101, 3, 0, 10);
    upd("novalid",  0, 0, 4'b0000, 4'b1111, 4'b1101, 3, 0, 10);
    upd("pen2",     1, 0, 4'b0000, 4'b0100, 4'b1001, 2, 1, 11);
    upd("rew2_a",   1, 0, 4'b0100, 4'b0000, 4'b1001, 2, 0, 12);
    upd("rew1",     1, 0, 4'b0010, 4'b0000, 4'b1001, 2, 0, 13);
    upd("rew2_b",   1, 0, 4'b0100, 4'b0000, 4'b1001, 2, 0, 14);
    upd("rew2_c",   1, 0, 4'b0100, 4'b0000, 4'b1001, 2, 0, 15);
    upd("rew2_sat", 1, 0, 4'b0100, 4'b0000, 4'b1001, 2, 0, 0);
    upd("pen2_up",  1, 0, 4'b0000, 4'b0100, 4'b1001, 2, 0, 1);
    upd("rew3",     1, 0, 4'b1000, 4'b0000, 4'b1001, 2, 0, 2);

    // Asynchronous reset in the middle of an accepted burst.
    bus.fb_valid = 1'b1;
    bus.penalty  = 4'b1111;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_all("midreset", 4'b1111, 4, 0, 0);
    clear_inputs();
    @(negedge clk) rst_n = 1'b1;
    upd("post_reset", 1, 0, 4'b0000, 4'b0001, 4'b1110, 3, 1, 1);

`ifdef TA_LOAD_EN
    // States [3,4,4,4]: load beats feedback and ignores freeze.
    bus.load_valid = 1'b1;
    bus.load_idx   = 2'd2;
    bus.load_state = 3'd0;
    upd("load2", 1, 1, 4'b0000, 4'b0100, 4'b1010, 2, 1, 1);
    bus.load_valid = 1'b1;
    bus.load_idx   = 2'd3;
    bus.load_state = 3'd7;
    upd("load3", 1, 0, 4'b0001, 4'b0000, 4'b1010, 2, 0, 2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
